// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART receiver definitions: FSM encoding, default frame parameters, counter sizing.
package uart_rx_oversampled_pkg;

  localparam int unsigned DefDbit       = 8;
  localparam int unsigned DefSbTick     = 16;
  localparam int unsigned DefOversample = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } rx_state_e;

  // The s counter is shared by the bit and stop phases, so it must cover the longer of the two.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned wa;
    int unsigned wb;
    wa = (a > 1) ? $clog2(a) : 1;
    wb = (b > 1) ? $clog2(b) : 1;
    return (wa > wb) ? wa : wb;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receiver-to-consumer byte stream: held byte with valid/ready plus error pulses.
interface uart_rx_oversampled_if
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DBIT = DefDbit
);

  logic [DBIT-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            frame_err;
  logic            overrun_err;

  modport master (
    output dout,
    output dout_valid,
    output frame_err,
    output overrun_err,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  overrun_err,
    output dout_ready
  );

endinterface

// File: rtl/uart_rx_oversampled_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rx_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d};
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready holding register.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DBIT       = DefDbit,
  parameter int unsigned SB_TICK    = DefSbTick,
  parameter int unsigned OVERSAMPLE = DefOversample
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  s_tick,
  uart_rx_oversampled_if.master out
);

  localparam int unsigned SW = cnt_width(OVERSAMPLE, SB_TICK);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] SHalf = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SFull = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  logic rx_s;

  rx_sync_2ff u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            byte_done;
  logic            stop_bad;

  logic [DBIT-1:0] dout_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      // Start detection runs every clock so the falling edge is not missed between ticks.
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SHalf) begin
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SFull) begin
            s_d     = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (n_q == NLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SStop) begin
            if (rx_s) begin
              byte_done = 1'b1;
              state_d   = StIdle;
            end else begin
              stop_bad = 1'b1;
              state_d  = StBreak;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      // A line held low after a bad stop bit must go high before a new start is accepted.
      StBreak: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= stop_bad;
      overrun_err_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || out.dout_ready) begin
          dout_q  <= shreg_q;
          valid_q <= 1'b1;
        end else begin
          overrun_err_q <= 1'b1;
        end
      end else if (valid_q && out.dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out.dout        = dout_q;
  assign out.dout_valid  = valid_q;
  assign out.frame_err   = frame_err_q;
  assign out.overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled with a byte scoreboard and error-pulse counters.
module tb_uart_rx_oversampled;
  import uart_rx_oversampled_pkg::*;

  logic clk;
  logic reset;
  logic rx;
  logic s_tick;

  uart_rx_oversampled_if #(.DBIT(8)) bus ();

  uart_rx_oversampled #(
    .DBIT       (8),
    .SB_TICK    (16),
    .OVERSAMPLE (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .out    (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_rx    = 0;
  int n_ferr  = 0;
  int n_oerr  = 0;
  logic [7:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clock tick every 27 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (26) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: time limit reached, observed unfinished expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples just after the falling edge, when all inputs have settled.
  always begin
    @(negedge clk);
    #1;
    if (bus.frame_err) n_ferr++;
    if (bus.overrun_err) n_oerr++;
    if (bus.dout_valid && bus.dout_ready) begin
      n_rx++;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("dout_byte", 32'(bus.dout), 32'(sb.pop_front()));
    end
  end

  task automatic wait_ticks(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  int base_rx;
  int base_ferr;
  int base_oerr;

  initial begin
    reset          = 1'b1;
    rx             = 1'b1;
    bus.dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_oerr", 32'(bus.overrun_err), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(4);

    // 1: single good byte
    base_rx = n_rx; base_ferr = n_ferr; base_oerr = n_oerr;
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_ticks(4);
    check("t1_count", 32'(n_rx - base_rx), 32'd1);
    check("t1_ferr", 32'(n_ferr - base_ferr), 32'd0);
    check("t1_oerr", 32'(n_oerr - base_oerr), 32'd0);
    check("t1_valid_low", 32'(bus.dout_valid), 32'd0);
    check("t1_dout_hold", 32'(bus.dout), 32'h55);

    // 2: short low glitch rejected in START
    base_rx = n_rx;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check("t2_count", 32'(n_rx - base_rx), 32'd0);
    check("t2_ferr", 32'(n_ferr - base_ferr), 32'd0);
    check("t2_state", 32'(dut.state_q), 32'(StIdle));

    // 3: framing error, held-low line, then recovery
    send_frame(8'hA3, 1'b0);
    rx = 1'b0;
    wait_ticks(40);
    check("t3_ferr", 32'(n_ferr - base_ferr), 32'd1);
    check("t3_state_break", 32'(dut.state_q), 32'(StBreak));
    check("t3_valid", 32'(bus.dout_valid), 32'd0);
    check("t3_count", 32'(n_rx - base_rx), 32'd0);
    check("t3_dout_hold", 32'(bus.dout), 32'h55);
    rx = 1'b1;
    wait_ticks(4);
    check("t3_state_idle", 32'(dut.state_q), 32'(StIdle));
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_ticks(4);
    check("t3_count2", 32'(n_rx - base_rx), 32'd1);
    check("t3_ferr2", 32'(n_ferr - base_ferr), 32'd1);

    // 4: overrun while consumer stalls
    base_rx = n_rx; base_ferr = n_ferr; base_oerr = n_oerr;
    bus.dout_ready = 1'b0;
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_ticks(4);
    check("t4_valid", 32'(bus.dout_valid), 32'd1);
    check("t4_dout", 32'(bus.dout), 32'h12);
    check("t4_oerr", 32'(n_oerr - base_oerr), 32'd1);
    check("t4_ferr", 32'(n_ferr - base_ferr), 32'd0);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.dout_ready = 1'b0;
    @(negedge clk);
    #1;
    check("t4_valid_drop", 32'(bus.dout_valid), 32'd0);
    check("t4_dout_hold", 32'(bus.dout), 32'h12);
    check("t4_count", 32'(n_rx - base_rx), 32'd1);
    bus.dout_ready = 1'b1;
    wait_ticks(4);

    // 5: back-to-back frames
    base_rx = n_rx; base_oerr = n_oerr;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h81);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    wait_ticks(4);
    check("t5_count", 32'(n_rx - base_rx), 32'd3);
    check("t5_ferr", 32'(n_ferr - base_ferr), 32'd0);
    check("t5_oerr", 32'(n_oerr - base_oerr), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset in the middle of data bit 4 of 0xC7
    base_rx = n_rx;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 3) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    rx = 1'b0;
    wait_ticks(8);
    check("t6_state_data", 32'(dut.state_q), 32'(StData));
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_rst_dout", 32'(bus.dout), 32'h00);
    check("t6_rst_valid", 32'(bus.dout_valid), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(StIdle));
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(24);
    check("t6_no_stray", 32'(n_rx - base_rx), 32'd0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_ticks(4);
    check("t6_count", 32'(n_rx - base_rx), 32'd1);
    check("t6_dout", 32'(bus.dout), 32'h5A);
    check("t6_ferr", 32'(n_ferr - base_ferr), 32'd0);
    check("t6_oerr", 32'(n_oerr - base_oerr), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
